// File: rtl/disp_rd_if.sv
// Bundle between disp_rd_arbiter and its surroundings: scheduling inputs,
// the SDRAM read-burst handshake and the shared display-FIFO write port.
interface disp_rd_if;
    logic        en;
    logic [8:0]  usedw_1;
    logic [8:0]  usedw_2;

    logic        rd_req;
    logic [21:0] rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_data_vld;

    logic        wr_1;
    logic        wr_2;
    logic [15:0] fifo_data;
    logic        fifo_sop;
    logic        fifo_eop;
    logic        busy;

    modport master (
        input  en, usedw_1, usedw_2, rd_ack, rd_data, rd_data_vld,
        output rd_req, rd_addr, wr_1, wr_2, fifo_data, fifo_sop, fifo_eop, busy
    );

    modport slave (
        output en, usedw_1, usedw_2, rd_ack, rd_data, rd_data_vld,
        input  rd_req, rd_addr, wr_1, wr_2, fifo_data, fifo_sop, fifo_eop, busy
    );
endinterface

// File: rtl/disp_rd_arbiter.sv
// Round-robin SDRAM burst-read scheduler for the colour and binary display FIFOs;
// tags returned pixels with frame start/end markers.
module disp_rd_arbiter #(
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned FIFO_LOW  = 256,
    parameter int unsigned FRAME_PIX = 307200,
    parameter logic [21:0] BASE_1    = 22'h000000,
    parameter logic [21:0] BASE_2    = 22'h080000
) (
    input  logic      clk,
    input  logic      rst_n,
    disp_rd_if.master bus
);

    localparam int unsigned BeatW      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);
    localparam logic [18:0] BurstLen19 = 19'(BURST_LEN);
    localparam logic [18:0] FramePix19 = 19'(FRAME_PIX);
    localparam logic [18:0] FrameLast  = 19'(FRAME_PIX - 1);
    localparam logic [9:0]  FifoLow    = 10'(FIFO_LOW);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StData
    } state_e;

    state_e           state_q, state_d;
    logic             sel_q, sel_d;     // 0: colour channel, 1: binary channel
    logic             last_q, last_d;
    logic [18:0]      pix_cnt_1_q, pix_cnt_1_d;
    logic [18:0]      pix_cnt_2_q, pix_cnt_2_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [21:0]      addr_q, addr_d;

    logic             wr_1_q, wr_2_q, sop_q, eop_q;
    logic [15:0]      data_q;

    logic             elig_1, elig_2, pick, wr_fire;
    logic [18:0]      pix_cnt_sel, pix_next, pix_wrap, pix_idx;

    assign elig_1      = {1'b0, bus.usedw_1} < FifoLow;
    assign elig_2      = {1'b0, bus.usedw_2} < FifoLow;
    assign pix_cnt_sel = sel_q ? pix_cnt_2_q : pix_cnt_1_q;
    assign pix_next    = pix_cnt_sel + BurstLen19;
    assign pix_wrap    = (pix_next == FramePix19) ? '0 : pix_next;
    assign pix_idx     = pix_cnt_sel + 19'(beat_q);
    assign wr_fire     = (state_q == StData) && bus.rd_data_vld;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        pix_cnt_1_d = pix_cnt_1_q;
        pix_cnt_2_d = pix_cnt_2_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        pick        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.en && (elig_1 || elig_2)) begin
                    // On a tie the channel not served last goes next.
                    pick    = (elig_1 && elig_2) ? ~last_q : elig_2;
                    sel_d   = pick;
                    addr_d  = pick ? (BASE_2 + {3'b000, pix_cnt_2_q})
                                   : (BASE_1 + {3'b000, pix_cnt_1_q});
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.rd_ack) begin
                    state_d = StData;
                    beat_d  = '0;
                end
            end
            StData: begin
                if (bus.rd_data_vld) begin
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatLast) begin
                        state_d = StIdle;
                        last_d  = sel_q;
                        if (sel_q) begin
                            pix_cnt_2_d = pix_wrap;
                        end else begin
                            pix_cnt_1_d = pix_wrap;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            pix_cnt_1_q <= '0;
            pix_cnt_2_q <= '0;
            beat_q      <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            pix_cnt_1_q <= pix_cnt_1_d;
            pix_cnt_2_q <= pix_cnt_2_d;
            beat_q      <= beat_d;
            addr_q      <= addr_d;
        end
    end

    // FIFO write port lags the returned beat by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_1_q <= 1'b0;
            wr_2_q <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            data_q <= '0;
        end else begin
            wr_1_q <= wr_fire && !sel_q;
            wr_2_q <= wr_fire && sel_q;
            sop_q  <= wr_fire && (pix_idx == '0);
            eop_q  <= wr_fire && (pix_idx == FrameLast);
            if (wr_fire) begin
                data_q <= bus.rd_data;
            end
        end
    end

    assign bus.rd_req    = (state_q == StReq);
    assign bus.rd_addr   = addr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.wr_1      = wr_1_q;
    assign bus.wr_2      = wr_2_q;
    assign bus.fifo_data = data_q;
    assign bus.fifo_sop  = sop_q;
    assign bus.fifo_eop  = eop_q;

endmodule

// File: tb/tb_disp_rd_arbiter.sv
// Scoreboard bench for disp_rd_arbiter: directed bursts push expected requests and
// writes; a monitor pops and compares whenever the DUT requests or writes.
module tb_disp_rd_arbiter;

    localparam int unsigned BURST = 256;
    localparam int unsigned FRAME = 1024;  // four bursts per frame keeps wrap tests short
    localparam logic [21:0] B1    = 22'h000000;
    localparam logic [21:0] B2    = 22'h080000;

    typedef struct {
        logic        ch;
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disp_rd_if bus ();

    disp_rd_arbiter #(
        .BURST_LEN (BURST),
        .FIFO_LOW  (256),
        .FRAME_PIX (FRAME),
        .BASE_1    (B1),
        .BASE_2    (B2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          wr1_cnt     = 0;
    int          wr2_cnt     = 0;
    wr_t         exp_q[$];
    logic [21:0] req_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_req"},    32'(bus.rd_req),    32'd0);
        chk({tag, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
        chk({tag, "_wr_1"},      32'(bus.wr_1),      32'd0);
        chk({tag, "_wr_2"},      32'(bus.wr_2),      32'd0);
        chk({tag, "_fifo_data"}, 32'(bus.fifo_data), 32'd0);
        chk({tag, "_fifo_sop"},  32'(bus.fifo_sop),  32'd0);
        chk({tag, "_fifo_eop"},  32'(bus.fifo_eop),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    task automatic do_reset();
        bus.en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Acts as the SDRAM controller for one burst the bench expects on channel ch at addr.
    task automatic serve_burst(input logic ch, input logic [21:0] addr, input int ack_dly,
                               input int drop_en_at, input int abort_at);
        int          n;
        int          off;
        wr_t         e;
        logic [15:0] d;
        off = int'(addr - (ch ? B2 : B1));
        req_q.push_back(addr);
        n = 0;
        while (!bus.rd_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_seen", 32'(bus.rd_req), 32'd1);
        if (!bus.rd_req) begin
            req_q.delete();
            return;
        end
        for (int i = 0; i < ack_dly; i++) begin
            chk("hold_rd_req",  32'(bus.rd_req),  32'd1);
            chk("hold_rd_addr", 32'(bus.rd_addr), 32'(addr));
            chk("hold_no_wr",   32'(bus.wr_1 | bus.wr_2), 32'd0);
            @(posedge clk); #1;
        end
        bus.rd_ack = 1'b1;
        @(posedge clk); #1;
        bus.rd_ack = 1'b0;
        chk("req_dropped", 32'(bus.rd_req), 32'd0);
        chk("busy_data",   32'(bus.busy),   32'd1);
        for (int b = 0; b < int'(BURST); b++) begin
            if (b == abort_at) begin
                bus.rd_data_vld = 1'b0;
                return;
            end
            if (b == drop_en_at) bus.en = 1'b0;
            d      = (addr[15:0] + 16'(b)) ^ (ch ? 16'h5a5a : 16'h0000);
            e.ch   = ch;
            e.data = d;
            e.sop  = (off + b == 0);
            e.eop  = (off + b == int'(FRAME) - 1);
            exp_q.push_back(e);
            bus.rd_data     = d;
            bus.rd_data_vld = 1'b1;
            @(posedge clk); #1;
            if (b % 37 == 36) begin
                bus.rd_data_vld = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.rd_data_vld = 1'b0;
    endtask

    initial begin : monitor
        logic req_prev;
        wr_t  e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rd_req && !req_prev) begin
                    chk("req_expected", 32'(req_q.size() != 0), 32'd1);
                    if (req_q.size() != 0) chk("rd_addr", 32'(bus.rd_addr), 32'(req_q.pop_front()));
                end
                if (bus.wr_1 || bus.wr_2) begin
                    if (bus.wr_1) wr1_cnt++;
                    if (bus.wr_2) wr2_cnt++;
                    chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_sel",    32'({bus.wr_2, bus.wr_1}), e.ch ? 32'd2 : 32'd1);
                        chk("fifo_data", 32'(bus.fifo_data), 32'(e.data));
                        chk("fifo_sop",  32'(bus.fifo_sop),  32'(e.sop));
                        chk("fifo_eop",  32'(bus.fifo_eop),  32'(e.eop));
                    end
                end else if (bus.fifo_sop || bus.fifo_eop) begin
                    chk("tag_without_wr", 32'({bus.fifo_sop, bus.fifo_eop}), 32'd0);
                end
            end
            req_prev = bus.rd_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        bus.en          = 1'b0;
        bus.usedw_1     = 9'd0;
        bus.usedw_2     = 9'd0;
        bus.rd_ack      = 1'b0;
        bus.rd_data     = 16'h0000;
        bus.rd_data_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        // Only channel 1 eligible: one burst at frame start, all writes to FIFO 1.
        bus.usedw_1 = 9'd10;
        bus.usedw_2 = 9'd300;
        bus.en      = 1'b1;
        rst_n       = 1'b1;
        serve_burst(1'b0, B1, 2, -1, -1);
        bus.en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_wr1_count", 32'(wr1_cnt), 32'd256);
        chk("t1_wr2_count", 32'(wr2_cnt), 32'd0);
        chk("t1_drained",   32'(exp_q.size()), 32'd0);

        // Both eligible: strict alternation starting with channel 1.
        do_reset();
        bus.usedw_1 = 9'd0;
        bus.usedw_2 = 9'd0;
        bus.en      = 1'b1;
        serve_burst(1'b0, 22'h000000, 1, -1, -1);
        serve_burst(1'b1, 22'h080000, 0, -1, -1);
        serve_burst(1'b0, 22'h000100, 3, -1, -1);
        serve_burst(1'b1, 22'h080100, 1, -1, -1);
        serve_burst(1'b0, 22'h000200, 0, -1, -1);
        bus.en = 1'b0;

        // Frame wrap on channel 1, with a long ack stall on the first request.
        do_reset();
        bus.usedw_1 = 9'd0;
        bus.usedw_2 = 9'd300;
        bus.en      = 1'b1;
        serve_burst(1'b0, 22'h000000, 20, -1, -1);
        serve_burst(1'b0, 22'h000100, 1, -1, -1);
        serve_burst(1'b0, 22'h000200, 1, -1, -1);
        serve_burst(1'b0, 22'h000300, 1, -1, -1);
        serve_burst(1'b0, 22'h000000, 1, -1, -1);
        bus.en = 1'b0;

        // en dropped mid-burst: burst completes, then nothing new until en returns.
        do_reset();
        bus.usedw_1 = 9'd0;
        bus.usedw_2 = 9'd0;
        bus.en      = 1'b1;
        serve_burst(1'b0, 22'h000000, 1, 100, -1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_low_rd_req", 32'(bus.rd_req), 32'd0);
            chk("en_low_busy",   32'(bus.busy),   32'd0);
        end
        chk("en_low_drained", 32'(exp_q.size()), 32'd0);
        bus.en = 1'b1;
        serve_burst(1'b1, 22'h080000, 1, -1, -1);
        bus.en = 1'b0;

        // Reset at beat 100, stray data while idle, then restart at frame start.
        do_reset();
        bus.usedw_1 = 9'd0;
        bus.usedw_2 = 9'd300;
        bus.en      = 1'b1;
        serve_burst(1'b0, 22'h000000, 1, -1, 100);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        chk("mid_reset_drained", 32'(exp_q.size()), 32'd0);
        bus.en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.rd_data     = 16'hdead;
        bus.rd_data_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stray_no_wr", 32'({bus.wr_2, bus.wr_1}), 32'd0);
        end
        @(posedge clk); #1;
        bus.rd_data_vld = 1'b0;
        bus.en = 1'b1;
        serve_burst(1'b0, 22'h000000, 1, -1, -1);
        bus.en = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_no_req",  32'(req_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_rd_arbiter.md
# disp_rd_arbiter

Read scheduler that shares one SDRAM read port between the two display FIFOs feeding the VGA output stage: channel 1 (colour frame) and channel 2 (binary edge frame). It watches both FIFO fill levels, issues fixed-length burst reads round-robin, and tags the returned pixels with frame start/end markers before writing them into the requesting FIFO. It sits between the SDRAM controller read interface and the two 512-deep display FIFOs.

## Interface
- BURST_LEN, 256, words per SDRAM read burst
- FIFO_LOW, 256, a channel is eligible when its usedw < FIFO_LOW
- FRAME_PIX, 307200, pixels per frame (640×480); must be a multiple of BURST_LEN
- BASE_1, 22'h000000, SDRAM word address of colour frame
- BASE_2, 22'h080000, SDRAM word address of binary frame
- clk  in  1  pixel/system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  scheduling enable; low blocks new bursts only
- usedw_1  in  9  colour FIFO fill level
- usedw_2  in  9  binary FIFO fill level
- rd_req  out  1  burst read request, held until rd_ack
- rd_addr  out  22  burst start address, stable while rd_req high
- rd_ack  in  1  controller accepted request (1-cycle pulse)
- rd_data  in  16  returned read data
- rd_data_vld  in  1  rd_data valid
- wr_1, wr_2  out  1  write strobe into colour / binary FIFO
- fifo_data  out  16  pixel data to both FIFOs
- fifo_sop  out  1  first pixel of frame (with wr_x)
- fifo_eop  out  1  last pixel of frame (with wr_x)
- busy  out  1  high in REQ or DATA

## Operation
- States: IDLE, REQ, DATA. Reset: IDLE; all outputs 0; pix_cnt_1 = pix_cnt_2 = 0; last = 2 (so channel 1 wins first tie).
- IDLE: elig_x = (usedw_x < FIFO_LOW). If en and any elig: sel ← eligible channel; if both, sel ← channel ≠ last. Next state REQ. Otherwise stay IDLE.
- REQ: rd_req = 1, rd_addr = BASE_sel + pix_cnt_sel. On rd_ack: → DATA, beat counter = 0.
- DATA: each rd_data_vld increments beat counter; on beat BURST_LEN-1: → IDLE, last ← sel, pix_cnt_sel += BURST_LEN, wrapping to 0 when result = FRAME_PIX.
- Write path: wr_sel registered copy of rd_data_vld in DATA; fifo_data = rd_data registered; fifo_sop = 1 when pixel index (pix_cnt_sel + beat) = 0; fifo_eop = 1 when index = FRAME_PIX-1. Non-selected wr_x stays 0.
- rd_data_vld outside DATA: ignored, nothing written.
- en deasserted in REQ/DATA: current burst completes normally; no new burst is issued.
- usedw sampled only in IDLE; changes during a burst have no effect.
- Address arithmetic 22-bit unsigned; pix_cnt 19-bit.
- rst_n assert mid-burst: immediate return to reset state; pointers restart at frame start (next writes carry sop).

## Timing
- IDLE decision → rd_req high next cycle; minimum one IDLE cycle between bursts.
- rd_req/rd_addr held constant until the cycle rd_ack is sampled high; rd_req low the following cycle.
- rd_data_vld at cycle t → wr_x/fifo_data/sop/eop at t+1.
- busy high from REQ entry until the cycle after last beat (state IDLE).
- Wrap: burst starting at FRAME_PIX-BURST_LEN (306944) carries eop on its last beat; next burst of that channel starts at BASE_x.

## Test plan
- Reset, usedw_1=10, usedw_2=300, en=1 → rd_req with rd_addr=0x000000; after rd_ack and 256 vld beats, 256 wr_1 pulses, first with fifo_sop=1, wr_2 never high.
- usedw_1=usedw_2=0 held → bursts alternate ch1, ch2, ch1…; ch1 addresses 0, 256, 512; ch2 addresses 0x080000, 0x080100.
- Drive ch1 through 1200 bursts → burst 1200 starts at 306944 with eop on beat 255; burst 1201 starts at 0x000000 with sop.
- Hold rd_ack low 20 cycles → rd_req and rd_addr stable all 20 cycles; no writes.
- Drop en mid-DATA → remaining beats written, then IDLE with rd_req=0 while both channels eligible.
- Assert rst_n low at beat 100 → all outputs 0 asynchronously; after release, first ch1 burst at 0x000000 with sop; stray rd_data_vld while IDLE produces no wr_x.
